// File: rtl/control_pkg.sv
// Shared definitions for the control pipeline: opcodes, ALU/RAM/writeback
// encodings and the per-stage control bundle carried from EX to WB.
package control_pkg;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_SETHI = 8'h0B;
   localparam logic [7:0] OP_BNE   = 8'h12;
   localparam logic [7:0] OP_CALL  = 8'h40;
   localparam logic [7:0] OP_JMPL  = 8'h81;
   localparam logic [7:0] OP_SUBCC = 8'h86;
   localparam logic [7:0] OP_ADD   = 8'h8A;
   localparam logic [7:0] OP_LD    = 8'hC0;
   localparam logic [7:0] OP_LDUH  = 8'hC2;
   localparam logic [7:0] OP_LDUB  = 8'hC4;
   localparam logic [7:0] OP_ST    = 8'hC8;
   localparam logic [7:0] OP_STB   = 8'hCA;
   localparam logic [7:0] OP_STH   = 8'hCE;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SETHI = 4'd5
   } alu_op_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } ram_size_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_CALL = 2'b10,
      WB_JMPL = 2'b11
   } wb_sel_e;

   typedef struct packed {
      logic      valid;
      alu_op_e   alu_op;
      logic      alu_src;
      logic      psr_en;
      logic      branch;
      logic      call;
      logic      jmpl;
      logic      target_sel;
      logic      ram_en;
      logic      ram_rw;
      ram_size_e ram_size;
      logic      load;
      logic      rf_le;
      wb_sel_e   wb_sel;
   } stage_ctl_t;

   localparam stage_ctl_t CTL_BUBBLE = '0;

endpackage

// File: rtl/control_pipe_if.sv
// Instruction input, pipeline controls and the EX/MEM/WB control bundles.
// The upstream stage presents instr/instr_valid and must hold instr while stall=1.
interface control_pipe_if #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
);
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              LE;
   logic              flush;
   logic              stall;

   logic              ex_valid;
   logic [3:0]        ex_alu_op;
   logic              ex_alu_src;
   logic              ex_psr_en;
   logic              ex_branch;
   logic              ex_call;
   logic              ex_jmpl;
   logic              ex_target_sel;
   logic [DATA_W-1:0] ex_imm;
   logic [RA_W-1:0]   ex_rs1;
   logic [RA_W-1:0]   ex_rs2;
   logic [RA_W-1:0]   ex_rd;

   logic              mem_valid;
   logic              mem_ram_en;
   logic              mem_ram_rw;
   logic [1:0]        mem_ram_size;
   logic              mem_load;
   logic [RA_W-1:0]   mem_rd;

   logic              wb_valid;
   logic              wb_rf_le;
   logic [1:0]        wb_sel;
   logic [RA_W-1:0]   wb_rd;

   logic              illegal_op;

   modport master (
      output instr, instr_valid, LE, flush,
      input  stall,
      input  ex_valid, ex_alu_op, ex_alu_src, ex_psr_en, ex_branch, ex_call,
             ex_jmpl, ex_target_sel, ex_imm, ex_rs1, ex_rs2, ex_rd,
      input  mem_valid, mem_ram_en, mem_ram_rw, mem_ram_size, mem_load, mem_rd,
      input  wb_valid, wb_rf_le, wb_sel, wb_rd,
      input  illegal_op
   );

   modport slave (
      input  instr, instr_valid, LE, flush,
      output stall,
      output ex_valid, ex_alu_op, ex_alu_src, ex_psr_en, ex_branch, ex_call,
             ex_jmpl, ex_target_sel, ex_imm, ex_rs1, ex_rs2, ex_rd,
      output mem_valid, mem_ram_en, mem_ram_rw, mem_ram_size, mem_load, mem_rd,
      output wb_valid, wb_rf_le, wb_sel, wb_rd,
      output illegal_op
   );
endinterface

// File: rtl/control_decode.sv
// Combinational ID-stage decoder: opcode in instr[31:24] to a control bundle
// plus immediate and register fields. Unknown or absent instructions give a bubble.
module control_decode
   import control_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RA_W     = 5,
   parameter int LINK_REG = 15
) (
   input  logic [DATA_W-1:0] instr,
   input  logic              instr_valid,
   output stage_ctl_t        ctl,
   output logic [DATA_W-1:0] imm,
   output logic [RA_W-1:0]   rs1,
   output logic [RA_W-1:0]   rs2,
   output logic [RA_W-1:0]   rd,
   output logic              illegal
);

   logic [7:0] opcode;
   logic       known;
   stage_ctl_t raw;

   assign opcode = instr[31:24];

   always_comb begin
      raw   = CTL_BUBBLE;
      known = 1'b1;
      imm   = DATA_W'($signed(instr[15:0]));
      rs1   = RA_W'(instr[23:19]);
      rs2   = RA_W'(instr[18:14]);
      rd    = RA_W'(instr[4:0]);
      unique case (opcode)
         OP_ADD: raw.rf_le = 1'b1;
         OP_SUBCC: begin
            raw.alu_op  = ALU_SUB;
            raw.alu_src = 1'b1;
            raw.psr_en  = 1'b1;
            raw.rf_le   = 1'b1;
         end
         OP_SETHI: begin
            raw.alu_op = ALU_SETHI;
            raw.rf_le  = 1'b1;
            imm        = DATA_W'({instr[21:0], 10'b0});
         end
         OP_LDUB, OP_LDUH, OP_LD: begin
            raw.ram_en   = 1'b1;
            raw.load     = 1'b1;
            raw.rf_le    = 1'b1;
            raw.wb_sel   = WB_LOAD;
            raw.ram_size = (opcode == OP_LDUB) ? SIZE_BYTE :
                           (opcode == OP_LDUH) ? SIZE_HALF : SIZE_WORD;
         end
         OP_STB, OP_STH, OP_ST: begin
            raw.ram_en   = 1'b1;
            raw.ram_rw   = 1'b1;
            raw.ram_size = (opcode == OP_STB) ? SIZE_BYTE :
                           (opcode == OP_STH) ? SIZE_HALF : SIZE_WORD;
         end
         OP_BNE: begin
            raw.branch     = 1'b1;
            raw.target_sel = 1'b1;
         end
         OP_CALL: begin
            raw.call   = 1'b1;
            raw.rf_le  = 1'b1;
            raw.wb_sel = WB_CALL;
            rd         = RA_W'(LINK_REG);
         end
         OP_JMPL: begin
            raw.jmpl   = 1'b1;
            raw.rf_le  = 1'b1;
            raw.wb_sel = WB_JMPL;
         end
         OP_NOP: ;
         default: known = 1'b0;
      endcase
      // r0 is hardwired, so no stage may ever request a write to it.
      if (rd == '0) raw.rf_le = 1'b0;
      raw.valid = 1'b1;
   end

   assign illegal = instr_valid & ~known;
   assign ctl     = (instr_valid & known) ? raw : CTL_BUBBLE;

endmodule

// File: rtl/control_pipe.sv
// ID->EX->MEM->WB control pipeline with load-use stall and EX-resolved flush.
// Decode is combinational on the ID instruction; each later stage is a register.
module control_pipe
   import control_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RA_W     = 5,
   parameter int LINK_REG = 15
) (
   input logic         clk,
   input logic         rst,
   control_pipe_if.slave bus
);

   stage_ctl_t        dec_ctl;
   logic [DATA_W-1:0] dec_imm;
   logic [RA_W-1:0]   dec_rs1, dec_rs2, dec_rd;
   logic              dec_illegal;

   stage_ctl_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
   logic [RA_W-1:0]   ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
   logic [RA_W-1:0]   mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
   logic              illegal_q, illegal_d;
   logic              stall;

   control_decode #(
      .DATA_W   (DATA_W),
      .RA_W     (RA_W),
      .LINK_REG (LINK_REG)
   ) u_decode (
      .instr       (bus.instr),
      .instr_valid (bus.instr_valid),
      .ctl         (dec_ctl),
      .imm         (dec_imm),
      .rs1         (dec_rs1),
      .rs2         (dec_rs2),
      .rd          (dec_rd),
      .illegal     (dec_illegal)
   );

   // Independent of LE so upstream can keep holding instr while frozen.
   assign stall = ex_q.valid & ex_q.load & (ex_rd_q != '0) & dec_ctl.valid &
                  ((ex_rd_q == dec_rs1) | (ex_rd_q == dec_rs2));

   always_comb begin
      ex_d      = ex_q;
      ex_imm_d  = ex_imm_q;
      ex_rs1_d  = ex_rs1_q;
      ex_rs2_d  = ex_rs2_q;
      ex_rd_d   = ex_rd_q;
      mem_d     = mem_q;
      mem_rd_d  = mem_rd_q;
      wb_d      = wb_q;
      wb_rd_d   = wb_rd_q;
      illegal_d = illegal_q | dec_illegal;
      if (bus.LE) begin
         wb_d     = mem_q;
         wb_rd_d  = mem_rd_q;
         mem_d    = ex_q;
         mem_rd_d = ex_rd_q;
         if (bus.flush || stall || !dec_ctl.valid) begin
            ex_d     = CTL_BUBBLE;
            ex_imm_d = '0;
            ex_rs1_d = '0;
            ex_rs2_d = '0;
            ex_rd_d  = '0;
         end else begin
            ex_d     = dec_ctl;
            ex_imm_d = dec_imm;
            ex_rs1_d = dec_rs1;
            ex_rs2_d = dec_rs2;
            ex_rd_d  = dec_rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q      <= CTL_BUBBLE;
         ex_imm_q  <= '0;
         ex_rs1_q  <= '0;
         ex_rs2_q  <= '0;
         ex_rd_q   <= '0;
         mem_q     <= CTL_BUBBLE;
         mem_rd_q  <= '0;
         wb_q      <= CTL_BUBBLE;
         wb_rd_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         ex_q      <= ex_d;
         ex_imm_q  <= ex_imm_d;
         ex_rs1_q  <= ex_rs1_d;
         ex_rs2_q  <= ex_rs2_d;
         ex_rd_q   <= ex_rd_d;
         mem_q     <= mem_d;
         mem_rd_q  <= mem_rd_d;
         wb_q      <= wb_d;
         wb_rd_q   <= wb_rd_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.stall         = stall;
   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_alu_op     = ex_q.alu_op;
   assign bus.ex_alu_src    = ex_q.alu_src;
   assign bus.ex_psr_en     = ex_q.psr_en;
   assign bus.ex_branch     = ex_q.branch;
   assign bus.ex_call       = ex_q.call;
   assign bus.ex_jmpl       = ex_q.jmpl;
   assign bus.ex_target_sel = ex_q.target_sel;
   assign bus.ex_imm        = ex_imm_q;
   assign bus.ex_rs1        = ex_rs1_q;
   assign bus.ex_rs2        = ex_rs2_q;
   assign bus.ex_rd         = ex_rd_q;
   assign bus.mem_valid     = mem_q.valid;
   assign bus.mem_ram_en    = mem_q.ram_en;
   assign bus.mem_ram_rw    = mem_q.ram_rw;
   assign bus.mem_ram_size  = mem_q.ram_size;
   assign bus.mem_load      = mem_q.load;
   assign bus.mem_rd        = mem_rd_q;
   assign bus.wb_valid      = wb_q.valid;
   assign bus.wb_rf_le      = wb_q.rf_le;
   assign bus.wb_sel        = wb_q.wb_sel;
   assign bus.wb_rd         = wb_rd_q;
   assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed scenarios, then random traffic
// compared each cycle against a slot-based behavioural pipeline model.
module tb_control_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   control_pipe_if #(.DATA_W(32), .RA_W(5)) bus ();

   control_pipe #(.DATA_W(32), .RA_W(5), .LINK_REG(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        v, ill, alu_chk, src, psr, br, call, jmpl, tsel;
      logic        ram, rw, ld, rf;
      logic [3:0]  alu;
      logic [1:0]  size, wsel;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
   } m_t;

   m_t   ex_m, mem_m, wb_m, dec_m, bub;
   logic ill_m, m_stall;
   int   n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [4:0] r1,
                                      input logic [4:0] r2, input logic [4:0] rd);
      return {op, r1, r2, 9'd0, rd};
   endfunction

   // Instruction table: what each opcode asks of the pipeline.
   function automatic m_t ref_decode(input logic [31:0] i, input logic iv);
      m_t   m;
      logic known;
      m = bub;
      known = 1'b1;
      m.rs1 = i[23:19];
      m.rs2 = i[18:14];
      m.rd  = i[4:0];
      m.imm = {{16{i[15]}}, i[15:0]};
      case (i[31:24])
         8'h8A: begin m.rf = 1; m.alu_chk = 1; m.alu = 4'd0; end
         8'h86: begin m.rf = 1; m.alu_chk = 1; m.alu = 4'd1; m.src = 1; m.psr = 1; end
         8'h0B: begin m.rf = 1; m.alu_chk = 1; m.alu = 4'd5; m.imm = {i[21:0], 10'b0}; end
         8'hC4: begin m.ram = 1; m.ld = 1; m.rf = 1; m.wsel = 2'b01; m.size = 2'b00; end
         8'hC2: begin m.ram = 1; m.ld = 1; m.rf = 1; m.wsel = 2'b01; m.size = 2'b01; end
         8'hC0: begin m.ram = 1; m.ld = 1; m.rf = 1; m.wsel = 2'b01; m.size = 2'b10; end
         8'hCA: begin m.ram = 1; m.rw = 1; m.size = 2'b00; end
         8'hCE: begin m.ram = 1; m.rw = 1; m.size = 2'b01; end
         8'hC8: begin m.ram = 1; m.rw = 1; m.size = 2'b10; end
         8'h12: begin m.br = 1; m.tsel = 1; end
         8'h40: begin m.call = 1; m.rf = 1; m.rd = 5'd15; m.wsel = 2'b10; end
         8'h81: begin m.jmpl = 1; m.rf = 1; m.wsel = 2'b11; end
         8'h00: ;
         default: known = 1'b0;
      endcase
      if (m.rd == 5'd0) m.rf = 1'b0;
      m.v = iv && known;
      if (!m.v) m = bub;
      m.ill = iv && !known;
      return m;
   endfunction

   task automatic model_edge();
      if (rst) begin
         ex_m = bub; mem_m = bub; wb_m = bub; ill_m = 1'b0;
      end else begin
         if (dec_m.ill) ill_m = 1'b1;
         if (bus.LE) begin
            wb_m  = mem_m;
            mem_m = ex_m;
            ex_m  = (bus.flush || m_stall) ? bub : dec_m;
         end
      end
   endtask

   task automatic check_all();
      chk("ex_valid", bus.ex_valid, ex_m.v);
      chk("ex_alu_src", bus.ex_alu_src, ex_m.src);
      chk("ex_psr_en", bus.ex_psr_en, ex_m.psr);
      chk("ex_branch", bus.ex_branch, ex_m.br);
      chk("ex_call", bus.ex_call, ex_m.call);
      chk("ex_jmpl", bus.ex_jmpl, ex_m.jmpl);
      chk("ex_target_sel", bus.ex_target_sel, ex_m.tsel);
      if (ex_m.alu_chk) chk("ex_alu_op", bus.ex_alu_op, ex_m.alu);
      if (ex_m.v) begin
         chk("ex_imm", bus.ex_imm, ex_m.imm);
         chk("ex_rs1", bus.ex_rs1, ex_m.rs1);
         chk("ex_rs2", bus.ex_rs2, ex_m.rs2);
         chk("ex_rd", bus.ex_rd, ex_m.rd);
      end
      chk("mem_valid", bus.mem_valid, mem_m.v);
      chk("mem_ram_en", bus.mem_ram_en, mem_m.ram);
      chk("mem_ram_rw", bus.mem_ram_rw, mem_m.rw);
      chk("mem_load", bus.mem_load, mem_m.ld);
      if (mem_m.v) begin
         chk("mem_ram_size", bus.mem_ram_size, mem_m.size);
         chk("mem_rd", bus.mem_rd, mem_m.rd);
      end
      chk("wb_valid", bus.wb_valid, wb_m.v);
      chk("wb_rf_le", bus.wb_rf_le, wb_m.rf);
      if (wb_m.v) begin
         chk("wb_sel", bus.wb_sel, wb_m.wsel);
         chk("wb_rd", bus.wb_rd, wb_m.rd);
      end
      chk("illegal_op", bus.illegal_op, ill_m);
   endtask

   // Inputs are set just after a falling edge; outputs are checked at the next one.
   task automatic tick();
      dec_m   = ref_decode(bus.instr, bus.instr_valid);
      m_stall = ex_m.v && ex_m.ld && (ex_m.rd != 5'd0) && dec_m.v &&
                ((ex_m.rd == dec_m.rs1) || (ex_m.rd == dec_m.rs2));
      #1;
      chk("stall", bus.stall, m_stall);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input logic [31:0] i);
      bus.instr       = i;
      bus.instr_valid = 1'b1;
   endtask

   logic [7:0] ops [13] = '{8'h8A, 8'h86, 8'h0B, 8'hC4, 8'hC2, 8'hC0, 8'hCA,
                            8'hCE, 8'hC8, 8'h12, 8'h40, 8'h81, 8'h00};

   initial begin
      logic       take_new;
      logic [7:0] op;
      bub = '{default: '0};
      ex_m = bub; mem_m = bub; wb_m = bub; ill_m = 1'b0;
      rst = 1'b1;
      bus.instr = '0; bus.instr_valid = 1'b0; bus.LE = 1'b1; bus.flush = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_wb_sel", bus.wb_sel, 2'b00);
      chk("rst_ex_imm", bus.ex_imm, 32'd0);
      chk("rst_illegal", bus.illegal_op, 1'b0);

      // add r1,r2 -> r3 then nops
      drive(mk(8'h8A, 5'd1, 5'd2, 5'd3));
      tick();
      chk("add_ex_alu_op", bus.ex_alu_op, 4'd0);
      chk("add_ex_valid", bus.ex_valid, 1'b1);
      drive(mk(8'h00, 5'd0, 5'd0, 5'd0));
      tick();
      tick();
      chk("add_wb_rf_le", bus.wb_rf_le, 1'b1);
      chk("add_wb_rd", bus.wb_rd, 5'd3);

      // load-use: ld r4 then add using r4
      drive(mk(8'hC0, 5'd1, 5'd2, 5'd4));
      tick();
      drive(mk(8'h8A, 5'd4, 5'd1, 5'd6));
      #1 chk("lu_stall_hi", bus.stall, 1'b1);
      tick();
      chk("lu_ex_bubble", bus.ex_valid, 1'b0);
      chk("lu_mem_load", bus.mem_load, 1'b1);
      #1 chk("lu_stall_lo", bus.stall, 1'b0);
      tick();
      chk("lu_add_ex_rd", bus.ex_rd, 5'd6);
      drive(mk(8'h00, 5'd0, 5'd0, 5'd0));
      tick();
      tick();
      chk("lu_add_wb_valid", bus.wb_valid, 1'b1);
      chk("lu_add_wb_rd", bus.wb_rd, 5'd6);

      // call, then flush while call is in EX
      drive(mk(8'h40, 5'd0, 5'd0, 5'd0));
      tick();
      drive(mk(8'h8A, 5'd1, 5'd1, 5'd9));
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fl_ex_killed", bus.ex_valid, 1'b0);
      drive(mk(8'h00, 5'd0, 5'd0, 5'd0));
      tick();
      chk("fl_wb_rd", bus.wb_rd, 5'd15);
      chk("fl_wb_sel", bus.wb_sel, 2'b10);
      chk("fl_ex_not_add", bus.ex_rd, 5'd0);

      // jmpl r0, then an unknown opcode
      drive(mk(8'h81, 5'd2, 5'd0, 5'd0));
      tick();
      drive(32'hFF00_0000);
      tick();
      chk("ill_set", bus.illegal_op, 1'b1);
      chk("ill_bubble", bus.ex_valid, 1'b0);
      drive(mk(8'h00, 5'd0, 5'd0, 5'd0));
      tick();
      chk("jmpl_wb_rf_le", bus.wb_rf_le, 1'b0);
      chk("jmpl_wb_sel", bus.wb_sel, 2'b11);
      tick();
      chk("ill_sticky", bus.illegal_op, 1'b1);

      // LE=0 freeze, then reset together with flush
      drive(mk(8'h8A, 5'd1, 5'd2, 5'd7));
      tick();
      drive(mk(8'h86, 5'd3, 5'd4, 5'd8));
      tick();
      bus.LE = 1'b0;
      drive(mk(8'h0B, 5'd5, 5'd5, 5'd10));
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("frz_ex_rd", bus.ex_rd, 5'd8);
         chk("frz_mem_rd", bus.mem_rd, 5'd7);
         chk("frz_ex_alu_op", bus.ex_alu_op, 4'd1);
      end
      rst = 1'b1; bus.flush = 1'b1; bus.LE = 1'b1;
      tick();
      rst = 1'b0; bus.flush = 1'b0;
      chk("rf_ex_valid", bus.ex_valid, 1'b0);
      chk("rf_mem_valid", bus.mem_valid, 1'b0);
      chk("rf_wb_valid", bus.wb_valid, 1'b0);
      chk("rf_wb_rf_le", bus.wb_rf_le, 1'b0);
      chk("rf_wb_sel", bus.wb_sel, 2'b00);
      chk("rf_ex_rd", bus.ex_rd, 5'd0);
      chk("rf_ex_imm", bus.ex_imm, 32'd0);
      chk("rf_illegal", bus.illegal_op, 1'b0);

      // random traffic; upstream holds instr until the pipe takes it
      take_new = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (take_new) begin
            op = ($urandom_range(0, 24) == 0) ? 8'hFF : ops[$urandom_range(0, 12)];
            bus.instr = {op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                         9'($urandom), 5'($urandom_range(0, 5))};
            bus.instr[13:5] = 9'($urandom);
            bus.instr_valid = ($urandom_range(0, 9) != 0);
         end
         bus.LE    = ($urandom_range(0, 6) != 0);
         bus.flush = ($urandom_range(0, 7) == 0);
         rst       = ($urandom_range(0, 59) == 0);
         tick();
         take_new = rst || (bus.LE && (!m_stall || bus.flush));
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
